// File: rtl/queue_wr_arbiter.sv
// queue_wr_arbiter
// Round-robin arbiter that shares the write port of one valid/ready queue
// between NUM_REQ requesters. A winner keeps the grant for up to MAX_BURST
// beats. The owner's payload and index are passed straight through to the
// queue write side with no added latency.
//
// Ports:
//   clk_i        clock
//   rstn_i       asynchronous active-low reset
//   req_valid_i  per-requester valid
//   req_ready_o  per-requester ready (at most one bit high)
//   req_data_i   packed payloads, requester k at [k*DATA_SIZE +: DATA_SIZE]
//   out_valid_o  valid towards the queue write port
//   out_ready_i  ready from the queue write port
//   out_data_o   payload of the current owner
//   out_id_o     index of the current owner
//   grant_o      one-hot owner, zero while idle
//   busy_o       high while a requester owns the port

`ifdef ASSERTION
// Property checker for the arbiter's safety invariants.
module queue_wr_arbiter_chk #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input logic               clk_i,
  input logic               rstn_i,
  input logic [NUM_REQ-1:0] grant_o,
  input logic [NUM_REQ-1:0] req_ready_o,
  input logic [CNT_W-1:0]   beat_cnt_r,
  input logic               busy_o,
  input logic               out_valid_o
);
  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0(grant_o));
  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0(req_ready_o));
  a_beat_cnt_range : assert property (@(posedge clk_i) disable iff (!rstn_i)
    int'(beat_cnt_r) < MAX_BURST);
  a_no_valid_idle : assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(!busy_o && out_valid_o));
endmodule
`endif

module queue_wr_arbiter #(
  parameter int  NUM_REQ   = 4,
  parameter int  DATA_SIZE = 16,
  parameter int  MAX_BURST = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_SIZE-1:0]         out_data_o,
  output logic [IDW-1:0]               out_id_o,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         busy_o
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  generate
    if (NUM_REQ < 2) begin : g_bad_num_req
      $error("queue_wr_arbiter: NUM_REQ must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("queue_wr_arbiter: MAX_BURST must be >= 1");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [IDW-1:0]   owner_r, owner_s;
  logic [IDW-1:0]   rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0] beat_cnt_r, beat_cnt_s;
  logic [IDW-1:0]   next_ptr_s;
  logic [IDW:0]     pick_idle_s;
  logic [IDW:0]     pick_rel_s;
  logic             handshake_s;
  logic             release_s;

  // Round-robin pick: returns {found, index} of the first set valid bit at
  // or above ptr, wrapping. The loop runs downward so the lowest offset wins.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IDW-1:0]     ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (valid[idx]) begin
        res = {1'b1, IDW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Candidate pointers and winners for both the idle pick and a release.
  always_comb begin
    if (owner_r == IDW'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + IDW'(1);
    end
    pick_idle_s = rr_pick(req_valid_i, rr_ptr_r);
    pick_rel_s  = rr_pick(req_valid_i, next_ptr_s);
  end

  // Next-state logic and combinational pass-through of the owner's channel.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    rr_ptr_s    = rr_ptr_r;
    beat_cnt_s  = beat_cnt_r;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_id_o    = '0;
    grant_o     = '0;
    req_ready_o = '0;
    busy_o      = 1'b0;
    handshake_s = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_idle_s[IDW]) begin
          state_s    = ST_LOCKED;
          owner_s    = pick_idle_s[IDW-1:0];
          beat_cnt_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        busy_o               = 1'b1;
        out_valid_o          = req_valid_i[owner_r];
        out_data_o           = req_data_i[int'(owner_r)*DATA_SIZE +: DATA_SIZE];
        out_id_o             = owner_r;
        grant_o              = NUM_REQ'(1) << owner_r;
        req_ready_o[owner_r] = out_ready_i;
        handshake_s          = req_valid_i[owner_r] && out_ready_i;
        // Release on the last beat of the burst or when the owner goes quiet.
        release_s = (handshake_s && (beat_cnt_r == LAST_BEAT)) ||
                    !req_valid_i[owner_r];
        if (release_s) begin
          rr_ptr_s   = next_ptr_s;
          beat_cnt_s = '0;
          // Hand over in the same cycle so back-to-back bursts have no bubble.
          if (pick_rel_s[IDW]) begin
            state_s = ST_LOCKED;
            owner_s = pick_rel_s[IDW-1:0];
          end else begin
            state_s = ST_IDLE;
          end
        end else if (handshake_s) begin
          beat_cnt_s = beat_cnt_r + CNT_W'(1);
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        owner_s    = '0;
        rr_ptr_s   = '0;
        beat_cnt_s = '0;
      end
    endcase
  end

  // State, owner, round-robin pointer and beat counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r    <= ST_IDLE;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      rr_ptr_r   <= rr_ptr_s;
      beat_cnt_r <= beat_cnt_s;
    end
  end

`ifdef ASSERTION
  queue_wr_arbiter_chk #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .grant_o     (grant_o),
    .req_ready_o (req_ready_o),
    .beat_cnt_r  (beat_cnt_r),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o)
  );
`endif

endmodule
